// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data memory arbiter, its two requesters and the data memory.
// slave = arbiter side, master = requesters plus memory.
interface data_mem_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic          clear_req;
    logic          clear_busy;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_data_out;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        input  clear_req,
        output clear_busy,
        output mem_addr, mem_data_in, mem_write, mem_read,
        input  mem_data_out
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        output clear_req,
        input  clear_busy,
        input  mem_addr, mem_data_in, mem_write, mem_read,
        output mem_data_out
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory between two requesters; all outputs registered.
// Define MEM_ARB_CLEAR_EN to build the clear sequencer (CLEAR state, word counter, clear_busy).
module data_mem_arbiter #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 16
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS
`ifdef MEM_ARB_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    typedef struct packed {
        logic          r0_gnt;
        logic          r0_rvalid;
        logic [DW-1:0] r0_rdata;
        logic          r1_gnt;
        logic          r1_rvalid;
        logic [DW-1:0] r1_rdata;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_data_in;
        logic          mem_write;
        logic          mem_read;
        logic          clear_busy;
    } out_t;

    state_t state_q, state_d;
    logic   last_q, last_d;    // requester granted most recently
    logic   owner_q, owner_d;  // requester owning the access in flight
    out_t   out_q, out_d;
    logic   win;
    logic   pick;
`ifdef MEM_ARB_CLEAR_EN
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        // NOTE: every variable is given a default first, so no path through the case can infer a latch.
        state_d            = state_q;
        last_d             = last_q;
        owner_d            = owner_q;
        out_d              = out_q;
        out_d.r0_gnt       = 1'b0;
        out_d.r1_gnt       = 1'b0;
        out_d.r0_rvalid    = 1'b0;
        out_d.r1_rvalid    = 1'b0;
        out_d.mem_write    = 1'b0;
        out_d.mem_read     = 1'b0;
        out_d.clear_busy   = 1'b0;
        win                = 1'b0;
        pick               = 1'b0;
`ifdef MEM_ARB_CLEAR_EN
        cnt_d              = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.r0_req && bus.r1_req) begin
                    win  = 1'b1;
                    pick = ~last_q;
                end else if (bus.r0_req) begin
                    win  = 1'b1;
                    pick = 1'b0;
                end else if (bus.r1_req) begin
                    win  = 1'b1;
                    pick = 1'b1;
                end
`ifdef MEM_ARB_CLEAR_EN
                // A clear request outranks any pending access.
                if (bus.clear_req) begin
                    win               = 1'b0;
                    state_d           = CLEAR;
                    cnt_d             = '0;
                    out_d.mem_addr    = '0;
                    out_d.mem_data_in = '0;
                    out_d.mem_write   = 1'b1;
                    out_d.clear_busy  = 1'b1;
                end
`endif
                if (win) begin
                    out_d.mem_addr    = pick ? bus.r1_addr  : bus.r0_addr;
                    out_d.mem_data_in = pick ? bus.r1_wdata : bus.r0_wdata;
                    out_d.mem_write   = pick ? bus.r1_we    : bus.r0_we;
                    out_d.mem_read    = pick ? ~bus.r1_we   : ~bus.r0_we;
                    out_d.r0_gnt      = ~pick;
                    out_d.r1_gnt      = pick;
                    last_d            = pick;
                    owner_d           = pick;
                    state_d           = ACCESS;
                end
            end

            ACCESS: begin
                // Memory read data is combinational on mem_addr, so it is valid by the end of this cycle.
                if (out_q.mem_read) begin
                    if (owner_q) begin
                        out_d.r1_rvalid = 1'b1;
                        out_d.r1_rdata  = bus.mem_data_out;
                    end else begin
                        out_d.r0_rvalid = 1'b1;
                        out_d.r0_rdata  = bus.mem_data_out;
                    end
                end
                state_d = IDLE;
            end

`ifdef MEM_ARB_CLEAR_EN
            CLEAR: begin
                out_d.mem_data_in = '0;
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d            = cnt_q + CW'(1);
                    out_d.mem_addr   = AW'(cnt_q + CW'(1));
                    out_d.mem_write  = 1'b1;
                    out_d.clear_busy = 1'b1;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            out_q   <= '0;
`ifdef MEM_ARB_CLEAR_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            out_q   <= out_d;
`ifdef MEM_ARB_CLEAR_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.r0_gnt      = out_q.r0_gnt;
    assign bus.r0_rvalid   = out_q.r0_rvalid;
    assign bus.r0_rdata    = out_q.r0_rdata;
    assign bus.r1_gnt      = out_q.r1_gnt;
    assign bus.r1_rvalid   = out_q.r1_rvalid;
    assign bus.r1_rdata    = out_q.r1_rdata;
    assign bus.mem_addr    = out_q.mem_addr;
    assign bus.mem_data_in = out_q.mem_data_in;
    assign bus.mem_write   = out_q.mem_write;
    assign bus.mem_read    = out_q.mem_read;
    assign bus.clear_busy  = out_q.clear_busy;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed timing tests plus random traffic against a
// transaction-level reference model. Clear tests follow MEM_ARB_CLEAR_EN.
module tb_data_mem_arbiter;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    data_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    data_mem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: synchronous write, combinational read, 0 beyond DEPTH.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk)
        if (bus.mem_write && bus.mem_addr < AW'(DEPTH)) mem[bus.mem_addr[3:0]] <= bus.mem_data_in;
    assign bus.mem_data_out = (bus.mem_addr < AW'(DEPTH)) ? mem[bus.mem_addr[3:0]] : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
        bus.clear_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid,
                               bus.mem_write, bus.mem_read, bus.clear_busy}, 0);
        check({tag, "_rdata"}, {bus.r0_rdata, bus.r1_rdata}, 0);
        check({tag, "_mem"}, {bus.mem_addr, bus.mem_data_in}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
    endtask

    // One access from an idle arbiter: gnt + strobe one cycle after the request, rvalid the cycle after.
    task automatic access(input int port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
        if (port == 0) begin
            bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end else begin
            bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end
        @(negedge clk);
        check("acc_gnt", {bus.r0_gnt, bus.r1_gnt}, (port == 0) ? 2'b10 : 2'b01);
        check("acc_strobe", {bus.mem_write, bus.mem_read}, {we, ~we});
        check("acc_mem_addr", bus.mem_addr, addr);
        if (we) check("acc_mem_data_in", bus.mem_data_in, wdata);
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
        @(negedge clk);
        check("acc_rvalid", {bus.r0_rvalid, bus.r1_rvalid},
              we ? 2'b00 : ((port == 0) ? 2'b10 : 2'b01));
        if (!we) check("acc_rdata", (port == 0) ? bus.r0_rdata : bus.r1_rdata, exp_rdata);
    endtask

    task automatic fill(input logic [DW-1:0] value);
        for (int i = 0; i < DEPTH; i++) access(0, 1'b1, AW'(i), value, '0);
    endtask

    task automatic raise(input int port);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + $urandom_range(0, 47))
                                        : AW'($urandom_range(0, DEPTH - 1));
        if (port == 0) begin
            bus.r0_req = 1'b1; bus.r0_we = 1'($urandom_range(0, 1));
            bus.r0_addr = a;   bus.r0_wdata = DW'($urandom);
        end else begin
            bus.r1_req = 1'b1; bus.r1_we = 1'($urandom_range(0, 1));
            bus.r1_addr = a;   bus.r1_wdata = DW'($urandom);
        end
    endtask

    // Reference model state: one access at most in flight, round-robin on ties.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_busy;
    int            m_owner;
    int            m_last;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    bit            e_gnt0, e_gnt1, e_rv0, e_rv1, e_wr, e_rd;
    logic [DW-1:0] e_rdata0, e_rdata1, rd_val;
    int            winner;
    logic [7:0]    seq0, seq1;
    int            n;
    bit            found;

    initial begin
        idle_inputs();
        do_reset();

        // Single read of preloaded word, then write/read-back on requester 1.
        access(0, 1'b1, 16'd3, 16'hBEEF, '0);
        access(0, 1'b0, 16'd3, '0, 16'hBEEF);
        access(1, 1'b1, 16'd9, 16'h1234, '0);
        check("wr_keeps_rdata", bus.r1_rdata, 16'h0000);
        access(1, 1'b0, 16'd9, '0, 16'h1234);
        // Out-of-range address passes through and still returns rvalid with 0.
        access(0, 1'b0, 16'h0020, '0, 16'h0000);

        // Contention from reset: grants alternate r0, r1, r0, r1.
        do_reset();
        bus.r0_req = 1'b1; bus.r0_addr = 16'd3;
        bus.r1_req = 1'b1; bus.r1_addr = 16'd9;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seq0[i] = bus.r0_gnt;
            seq1[i] = bus.r1_gnt;
        end
        idle_inputs();
        check("cont_r0_gnts", seq0, 8'b0001_0001);
        check("cont_r1_gnts", seq1, 8'b0100_0100);
        @(negedge clk);

        // Reset during an access abandons it: no rvalid follows.
        bus.r1_req = 1'b1; bus.r1_addr = 16'd9;
        @(negedge clk);
        check("rma_gnt", bus.r1_gnt, 1'b1);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        check_all_zero("rma");
        reset = 1'b0;

`ifdef MEM_ARB_CLEAR_EN
        // Full clear walks every address once with mem_write high.
        fill(16'hFFFF);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("clr_ctrl", {bus.clear_busy, bus.mem_write, bus.mem_read, bus.r0_gnt, bus.r1_gnt}, 5'b11000);
            check("clr_addr", bus.mem_addr, i);
            check("clr_data", bus.mem_data_in, 0);
            @(negedge clk);
        end
        check("clr_done", {bus.clear_busy, bus.mem_write}, 2'b00);
        access(0, 1'b0, 16'd0, '0, 16'h0000);
        access(1, 1'b0, 16'd7, '0, 16'h0000);
        access(0, 1'b0, 16'd15, '0, 16'h0000);

        // Clear and request in the same cycle: clear first, grant one cycle after busy drops.
        bus.clear_req = 1'b1;
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 16'd7;
        @(negedge clk);
        bus.clear_req = 1'b0;
        n = 0;
        while (bus.clear_busy && n < 40) begin
            check("cvr_no_gnt", {bus.r0_gnt, bus.r1_gnt}, 2'b00);
            n++;
            @(negedge clk);
        end
        check("cvr_busy_cycles", n, DEPTH);
        check("cvr_gnt_wait", bus.r0_gnt, 1'b0);
        @(negedge clk);
        check("cvr_gnt", bus.r0_gnt, 1'b1);
        bus.r0_req = 1'b0;
        @(negedge clk);
        check("cvr_rdata", {bus.r0_rvalid, bus.r0_rdata}, {1'b1, 16'h0000});

        // Reset at counter 5 leaves a partial clear.
        fill(16'hFFFF);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            if (bus.clear_busy && bus.mem_addr == 16'd5) found = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        check("rmc_reached_5", found, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rmc");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) access(0, 1'b0, AW'(i), '0, 16'h0000);
        access(1, 1'b0, 16'd6, '0, 16'hFFFF);
`else
        // Without the clear sequencer, clear_req is ignored.
        fill(16'hFFFF);
        bus.clear_req = 1'b1;
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 16'd7;
        @(negedge clk);
        check("noclr_gnt", {bus.r0_gnt, bus.clear_busy, bus.mem_write}, 3'b100);
        bus.r0_req = 1'b0;
        @(negedge clk);
        check("noclr_rdata", {bus.r0_rvalid, bus.r0_rdata}, {1'b1, 16'hFFFF});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noclr_idle", {bus.clear_busy, bus.mem_write, bus.r0_gnt}, 3'b000);
        end
        bus.clear_req = 1'b0;
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = DW'(i * 16'h1111) ^ 16'h5A5A;
            access(0, 1'b1, AW'(i), ref_mem[i], '0);
        end
        m_busy = 1'b0; m_last = 0;
        e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_wr = 0; e_rd = 0;
        e_rdata0 = '0; e_rdata1 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rnd_gnt", {bus.r0_gnt, bus.r1_gnt}, {e_gnt0, e_gnt1});
            check("rnd_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, {e_rv0, e_rv1});
            check("rnd_r0_rdata", bus.r0_rdata, e_rdata0);
            check("rnd_r1_rdata", bus.r1_rdata, e_rdata1);
            check("rnd_strobe", {bus.mem_write, bus.mem_read}, {e_wr, e_rd});
            if (e_wr || e_rd) check("rnd_mem_addr", bus.mem_addr, m_addr);
            if (e_wr) check("rnd_mem_data_in", bus.mem_data_in, m_din);

            if (bus.r0_gnt) bus.r0_req = 1'b0;
            if (bus.r1_gnt) bus.r1_req = 1'b0;
            if (!bus.r0_req && $urandom_range(0, 2) == 0) raise(0);
            if (!bus.r1_req && $urandom_range(0, 2) == 0) raise(1);

            e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_wr = 0; e_rd = 0;
            if (m_busy) begin
                if (m_we) begin
                    if (m_addr < AW'(DEPTH)) ref_mem[m_addr[3:0]] = m_din;
                end else begin
                    rd_val = (m_addr < AW'(DEPTH)) ? ref_mem[m_addr[3:0]] : '0;
                    if (m_owner == 0) begin e_rv0 = 1; e_rdata0 = rd_val; end
                    else              begin e_rv1 = 1; e_rdata1 = rd_val; end
                end
                m_busy = 1'b0;
            end else begin
                winner = -1;
                if (bus.r0_req && bus.r1_req) winner = 1 - m_last;
                else if (bus.r0_req)          winner = 0;
                else if (bus.r1_req)          winner = 1;
                if (winner >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = winner;
                    m_last  = winner;
                    m_we    = (winner == 0) ? bus.r0_we    : bus.r1_we;
                    m_addr  = (winner == 0) ? bus.r0_addr  : bus.r1_addr;
                    m_din   = (winner == 0) ? bus.r0_wdata : bus.r1_wdata;
                    e_gnt0  = (winner == 0);
                    e_gnt1  = (winner == 1);
                    e_wr    = m_we;
                    e_rd    = !m_we;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the 16-word x 16-bit data memory between two requesters: requester 0 (CPU load/store path) and requester 1 (debug/DMA port). Each access is granted with round-robin fairness. The block drives the memory's address, write-data, MemWrite and MemRead inputs from registers. It also contains an optional clear sequencer that zeroes every word one address per cycle, replacing the asynchronous bulk clear for normal operation.

Parameters:
DW, 16, data width of memory words and requester data buses
AW, 16, address width of requester and memory address buses
DEPTH, 16, number of memory words walked by the clear sequencer

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
r0_req  input  1  requester 0 access request, held until r0_gnt
r0_we  input  1  requester 0: 1 = write, 0 = read
r0_addr  input  AW  requester 0 word address
r0_wdata  input  DW  requester 0 write data
r0_gnt  output  1  one-cycle grant pulse, requester 0
r0_rvalid  output  1  one-cycle read-data-valid pulse, requester 0
r0_rdata  output  DW  requester 0 read data
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1
clear_req  input  1  request a full memory clear (level-sensitive, sampled in IDLE)
clear_busy  output  1  high while the clear sequence runs
mem_addr  output  AW  to memory addr
mem_data_in  output  DW  to memory data_in
mem_write  output  1  to memory MemWrite
mem_read  output  1  to memory MemRead
mem_data_out  input  DW  from memory data_out (combinational w.r.t. mem_addr)

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs = 0: gnt, rvalid, rdata, mem_*, clear_busy.
  - Reset mid-ACCESS or mid-CLEAR abandons the operation. No gnt or rvalid is issued. A partial clear stays partial.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, ACCESS, CLEAR.
- IDLE, evaluated each cycle in priority order:
  - clear_req=1 -> CLEAR; counter=0.
  - Else if only one req is high -> that requester wins.
  - Else if both are high -> the requester != last_grant wins.
  - On a win: latch the winner's addr/we/wdata into mem_addr / mem_data_in / mem_write=we / mem_read=~we; set that requester's gnt=1 for the next cycle; update last_grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_* and gnt are held stable for this whole cycle.
  - At the end of the cycle: if the access is a read, capture mem_data_out into that requester's rdata and pulse its rvalid in the following cycle.
  - Clear mem_write, mem_read and gnt; go to IDLE.
- Timing summary:
  - Request seen in IDLE at cycle t -> gnt and memory strobe in t+1 -> rvalid/rdata in t+2.
  - Maximum throughput is one access per 2 cycles.
- Writes: no rvalid; rdata keeps its previous value.
- Requesters drop req in the cycle after gnt. A req still high in IDLE at t+2 is treated as a new request.
- CLEAR:
  - clear_busy=1, mem_write=1, mem_read=0, mem_data_in=0, mem_addr=counter.
  - counter increments each cycle. The cycle with counter=DEPTH-1 is the last; then go to IDLE with clear_busy=0 and mem_write=0.
  - A clear takes exactly DEPTH cycles.
  - No gnt is issued during CLEAR; pending reqs wait.
  - last_grant is unchanged by a clear.
- Simultaneous events:
  - clear_req arriving during ACCESS is honoured at the next IDLE, ahead of any pending reqs.
  - clear_req held high after a clear finishes starts another clear.
- Addresses >= DEPTH are passed through unchanged. Memory returns 0 for such reads and rvalid still pulses.

Optional Feature:
MEM_ARB_CLEAR_EN
- Defined: CLEAR state, counter and clear_busy are implemented as above.
- Undefined: no CLEAR state. clear_req is ignored; clear_busy is tied 0. Arbitration is otherwise identical.

Test Plan:
- Reset then single read: preload mem[3]=16'hBEEF; r0_req=1, r0_we=0, r0_addr=3 at t -> r0_gnt=1, mem_read=1, mem_addr=3 at t+1; r0_rvalid=1, r0_rdata=16'hBEEF at t+2.
- Write then read back: r1 writes 16'h1234 to addr 9 -> r1_gnt at t+1 with mem_write=1, mem_data_in=16'h1234, no r1_rvalid; next r1 read of addr 9 -> r1_rdata=16'h1234.
- Contention: r0_req and r1_req held high together for 8 cycles after reset -> grants alternate r0, r1, r0, r1 (4 grants, one per 2 cycles).
- Clear: write 16'hFFFF to all 16 words; pulse clear_req -> clear_busy=1 for exactly 16 cycles with mem_addr 0..15 and mem_write=1; subsequent reads of addr 0, 7, 15 return 0.
- Clear vs request: clear_req and r0_req both rise in the same IDLE cycle -> CLEAR runs first, r0_gnt appears 1 cycle after clear_busy falls.
- Reset mid-clear: assert reset at clear counter=5 -> next cycle all outputs 0, state IDLE; words 0..4 read 0, word 6 retains 16'hFFFF.
